ysyx_24100012_mem_arb: RTL and testbench

Sequencer and arbiter for the single shared DPI-backed memory port. It multiplexes instruction fetch (IFU) and load/store (LSU) requests onto that one port using valid/ready handshakes. It inserts a programmable access latency and issues exactly one single-cycle read or write strobe per transaction. It sits between IFU/LSU and the RAM instance.

---
 rtl/ysyx_24100012_mem_arb.sv | 167 ++++++++++++++++
 tb/tb_ysyx_24100012_mem_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_mem_arb.sv
// Shared memory-port sequencer: round-robin IFU/LSU arbitration,
// fixed access latency, one read or write strobe per transaction.
module ysyx_24100012_mem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LAT        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_rsp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rsp_data,
  input  logic                  ifu_rsp_ready,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [DATA_WIDTH-1:0] lsu_len,
  output logic                  lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rsp_data,
  input  logic                  lsu_rsp_ready,
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [DATA_WIDTH-1:0] ram_length,
  output logic [ADDR_WIDTH-1:0] ram_inaddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_outaddr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int CW = $clog2(LAT) + 1;
  localparam logic IFU = 1'b0;
  localparam logic LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic                  ifu_v_q, ifu_v_d;
  logic [DATA_WIDTH-1:0] ifu_dat_q, ifu_dat_d;
  logic                  lsu_v_q, lsu_v_d;
  logic [DATA_WIDTH-1:0] lsu_dat_q, lsu_dat_d;

  logic gnt_ifu, gnt_lsu, idle, rsp_ack;
  logic [DATA_WIDTH-1:0] rd_val;

  // On a tie the requester that did not win last time goes first.
  assign gnt_ifu = ifu_req_valid &&
                   (!lsu_req_valid || last_q == LSU);
  assign gnt_lsu = lsu_req_valid &&
                   (!ifu_req_valid || last_q == IFU);
  assign idle    = state_q == IDLE;
  assign rsp_ack = (owner_q == LSU) ? lsu_rsp_ready
                                    : ifu_rsp_ready;
  assign rd_val  = wen_q ? '0 : ram_dout;

  assign ifu_req_ready = !rst && idle && gnt_ifu;
  assign lsu_req_ready = !rst && idle && gnt_lsu;

  assign ram_ren     = !rst && state_q == ACCESS && !wen_q;
  assign ram_wen     = !rst && state_q == ACCESS && wen_q;
  assign ram_inaddr  = addr_q;
  assign ram_outaddr = addr_q;
  assign ram_din     = wdata_q;
  assign ram_length  = len_q;

  assign ifu_rsp_valid = ifu_v_q;
  assign ifu_rsp_data  = ifu_dat_q;
  assign lsu_rsp_valid = lsu_v_q;
  assign lsu_rsp_data  = lsu_dat_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    len_d     = len_q;
    ifu_v_d   = ifu_v_q;
    ifu_dat_d = ifu_dat_q;
    lsu_v_d   = lsu_v_q;
    lsu_dat_d = lsu_dat_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_ifu || gnt_lsu) begin
          owner_d = gnt_lsu;
          last_d  = gnt_lsu;
          addr_d  = gnt_lsu ? lsu_addr : ifu_addr;
          wdata_d = gnt_lsu ? lsu_wdata : '0;
          wen_d   = gnt_lsu && lsu_wen;
          len_d   = gnt_lsu ? lsu_len : DATA_WIDTH'(4);
          cnt_d   = CW'(LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else cnt_d = cnt_q - CW'(1);
      end
      ACCESS: begin
        if (owner_q == LSU) begin
          lsu_v_d   = 1'b1;
          lsu_dat_d = rd_val;
        end else begin
          ifu_v_d   = 1'b1;
          ifu_dat_d = rd_val;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ack) begin
          ifu_v_d = 1'b0;
          lsu_v_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= IFU;
      last_q    <= IFU;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      len_q     <= '0;
      ifu_v_q   <= 1'b0;
      ifu_dat_q <= '0;
      lsu_v_q   <= 1'b0;
      lsu_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      len_q     <= len_d;
      ifu_v_q   <= ifu_v_d;
      ifu_dat_q <= ifu_dat_d;
      lsu_v_q   <= lsu_v_d;
      lsu_dat_q <= lsu_dat_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_mem_arb.sv
// Randomized scoreboard bench for the shared memory-port arbiter,
// plus a short directed run on a LAT=1 instance.
module tb_ysyx_24100012_mem_arb;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata, lsu_len;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rsp_data;
  logic        ram_wen, ram_ren;
  logic [31:0] ram_length, ram_inaddr, ram_din;
  logic [31:0] ram_outaddr, ram_dout;

  logic        b_rst, b_lsu_v, b_lsu_rdy, b_rsp_v;
  logic        b_ifu_rdy, b_ifu_rsp_v, b_rsp_rdy;
  logic [31:0] b_ifu_rsp_d, b_rsp_d;
  logic        b_wen, b_ren;
  logic [31:0] b_len, b_inaddr, b_din, b_outaddr, b_dout;
  logic [31:0] b_addr;

  ysyx_24100012_mem_arb #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_data(ifu_rsp_data),
    .ifu_rsp_ready(ifu_rsp_ready),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_len(lsu_len),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_data(lsu_rsp_data),
    .lsu_rsp_ready(lsu_rsp_ready),
    .ram_wen(ram_wen), .ram_ren(ram_ren),
    .ram_length(ram_length),
    .ram_inaddr(ram_inaddr), .ram_din(ram_din),
    .ram_outaddr(ram_outaddr), .ram_dout(ram_dout)
  );

  ysyx_24100012_mem_arb #(.LAT(1)) dut1 (
    .clk(clk), .rst(b_rst),
    .ifu_req_valid(1'b0),
    .ifu_req_ready(b_ifu_rdy),
    .ifu_addr(32'h0),
    .ifu_rsp_valid(b_ifu_rsp_v),
    .ifu_rsp_data(b_ifu_rsp_d),
    .ifu_rsp_ready(1'b1),
    .lsu_req_valid(b_lsu_v),
    .lsu_req_ready(b_lsu_rdy),
    .lsu_wen(1'b0), .lsu_addr(b_addr),
    .lsu_wdata(32'h0), .lsu_len(32'd1),
    .lsu_rsp_valid(b_rsp_v),
    .lsu_rsp_data(b_rsp_d),
    .lsu_rsp_ready(b_rsp_rdy),
    .ram_wen(b_wen), .ram_ren(b_ren),
    .ram_length(b_len),
    .ram_inaddr(b_inaddr), .ram_din(b_din),
    .ram_outaddr(b_outaddr), .ram_dout(b_dout)
  );

  function automatic logic [31:0] pat(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // Environment RAM: 256 words above 0x80000000.
  logic [31:0] mem [0:255];
  assign ram_dout = mem[ram_outaddr[9:2]];
  assign b_dout   = pat(b_outaddr);
  always @(posedge clk)
    if (ram_wen) mem[ram_inaddr[9:2]] <= ram_din;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               n, cyc, act, exp);
    end
  endtask

  // Reference model: an idealised word memory plus
  // a list of accepted transactions and their deadlines.
  typedef struct {
    bit          lsu;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] len;
    logic [31:0] data;
    int          strobe_cyc;
    int          rsp_cyc;
  } txn_t;

  txn_t        q[$];
  logic [31:0] ref_mem [logic [31:0]];
  bit          busy = 0;
  bit          last = 0;
  bit          mon_en = 0;
  bit          acc_i = 0, acc_l = 0;

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a);
  endfunction

  always @(negedge clk) begin
    bit ei, el, st, sr, sw, wi, wl;
    txn_t t;
    if (mon_en) begin
      ei = !rst && !busy && ifu_req_valid &&
           (!lsu_req_valid || last);
      el = !rst && !busy && lsu_req_valid &&
           (!ifu_req_valid || !last);
      chk("ifu_req_ready", {31'b0, ifu_req_ready},
          {31'b0, ei});
      chk("lsu_req_ready", {31'b0, lsu_req_ready},
          {31'b0, el});
      st = !rst && q.size() != 0 &&
           cyc == q[0].strobe_cyc;
      sr = 0;
      sw = 0;
      if (st) begin
        sr = !q[0].wen;
        sw = q[0].wen;
      end
      chk("ram_ren", {31'b0, ram_ren}, {31'b0, sr});
      chk("ram_wen", {31'b0, ram_wen}, {31'b0, sw});
      if (st) begin
        chk("ram_addr", ram_outaddr, q[0].addr);
        chk("ram_inaddr", ram_inaddr, q[0].addr);
        chk("ram_length", ram_length, q[0].len);
        if (q[0].wen) begin
          chk("ram_din", ram_din, q[0].wdata);
          ref_mem[q[0].addr] = q[0].wdata;
        end
      end
      wi = q.size() != 0 && !q[0].lsu &&
           cyc >= q[0].rsp_cyc;
      wl = q.size() != 0 && q[0].lsu &&
           cyc >= q[0].rsp_cyc;
      chk("ifu_rsp_valid", {31'b0, ifu_rsp_valid},
          {31'b0, wi});
      chk("lsu_rsp_valid", {31'b0, lsu_rsp_valid},
          {31'b0, wl});
      if (wi) chk("ifu_rsp_data", ifu_rsp_data, q[0].data);
      if (wl) chk("lsu_rsp_data", lsu_rsp_data, q[0].data);
      if (!rst && ((wi && ifu_rsp_ready) ||
                   (wl && lsu_rsp_ready))) begin
        void'(q.pop_front());
        busy = 0;
      end
      acc_i = ei;
      acc_l = el;
      if (ei || el) begin
        t.lsu   = el;
        t.wen   = el && lsu_wen;
        t.addr  = el ? lsu_addr : ifu_addr;
        t.wdata = el ? lsu_wdata : 32'h0;
        t.len   = el ? lsu_len : 32'd4;
        t.data  = t.wen ? 32'h0 : ref_rd(t.addr);
        t.strobe_cyc = cyc + 1 + LAT;
        t.rsp_cyc    = cyc + 2 + LAT;
        q.push_back(t);
        busy = 1;
        last = el;
      end
      if (rst) begin
        q.delete();
        busy = 0;
        last = 0;
        acc_i = 0;
        acc_l = 0;
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    return 32'h8000_0000 + {22'b0, 8'($urandom), 2'b00};
  endfunction

  function automatic logic [31:0] rand_len();
    int k;
    k = $urandom_range(0, 2);
    return (k == 0) ? 32'd1 : (k == 1) ? 32'd2 : 32'd4;
  endfunction

  int pv, pr, prst, t0;

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = pat(32'h8000_0000 + 32'(i * 4));
    rst = 1;
    ifu_req_valid = 0; lsu_req_valid = 0;
    ifu_addr = 0; lsu_addr = 0; lsu_wen = 0;
    lsu_wdata = 0; lsu_len = 0;
    ifu_rsp_ready = 0; lsu_rsp_ready = 0;
    b_rst = 1; b_lsu_v = 0; b_addr = 0; b_rsp_rdy = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ifu_rsp_valid", {31'b0, ifu_rsp_valid}, 0);
    chk("rst_lsu_rsp_valid", {31'b0, lsu_rsp_valid}, 0);
    chk("rst_ifu_rsp_data", ifu_rsp_data, 0);
    chk("rst_lsu_rsp_data", lsu_rsp_data, 0);
    chk("rst_strobes", {30'b0, ram_ren, ram_wen}, 0);
    mon_en = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (i < 600) begin
        pv = 100; pr = 100; prst = 0;
      end else if (i < 2800) begin
        pv = 60; pr = 50; prst = 2;
      end else begin
        pv = 80; pr = 15; prst = 1;
      end
      rst = $urandom_range(0, 99) < prst;
      if (!ifu_req_valid || acc_i) begin
        ifu_req_valid = $urandom_range(0, 99) < pv;
        ifu_addr = rand_addr();
      end
      if (!lsu_req_valid || acc_l) begin
        lsu_req_valid = $urandom_range(0, 99) < pv;
        lsu_addr  = rand_addr();
        lsu_wen   = $urandom_range(0, 1) == 1;
        lsu_wdata = $urandom;
        lsu_len   = rand_len();
      end
      ifu_rsp_ready = $urandom_range(0, 99) < pr;
      lsu_rsp_ready = $urandom_range(0, 99) < pr;
    end
    @(posedge clk);
    #1;
    rst = 0;
    ifu_req_valid = 0; lsu_req_valid = 0;
    ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    repeat (LAT + 4) @(posedge clk);
    #1 b_rst = 0;
    b_lsu_v = 1;
    b_addr = 32'h8000_0003;
    @(negedge clk);
    chk("l1_req_ready", {31'b0, b_lsu_rdy}, 1);
    @(posedge clk);
    #1 b_lsu_v = 0;
    @(negedge clk);
    chk("l1_no_early_ren", {31'b0, b_ren}, 0);
    @(negedge clk);
    chk("l1_ren", {31'b0, b_ren}, 1);
    chk("l1_wen", {31'b0, b_wen}, 0);
    chk("l1_len", b_len, 1);
    chk("l1_addr", b_outaddr, 32'h8000_0003);
    chk("l1_rsp_early", {31'b0, b_rsp_v}, 0);
    @(negedge clk);
    chk("l1_rsp_valid", {31'b0, b_rsp_v}, 1);
    chk("l1_rsp_data", b_rsp_d, pat(32'h8000_0003));
    chk("l1_ren_once", {31'b0, b_ren}, 0);
    @(negedge clk);
    chk("l1_rsp_clear", {31'b0, b_rsp_v}, 0);
    chk("l1_ifu_rsp", {31'b0, b_ifu_rsp_v}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
